// File: rtl/serial_arb_pkg.sv
// ----------------------------------------------------------------------------
// serial_arb_pkg : shared types and default sizes for serial_arbiter (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package serial_arb_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_arbiter_bit_counter.sv
// ----------------------------------------------------------------------------
// bit_counter : loadable bit counter with terminal-count flag (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module bit_counter
  import serial_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] len_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare against len-1 so a full-scale length never needs a wider counter.
  assign tc_o = (cnt_q == (len_i - 1'b1));

endmodule

`default_nettype wire

// File: rtl/serial_arbiter.sv
// ----------------------------------------------------------------------------
// serial_arbiter : round-robin owner of a shared serial channel (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module serial_arbiter
  import serial_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] nt,
  input  logic [N-1:0]   ser_in,
  output logic           ser_out,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [W-1:0]  len_q, len_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          ser_q, ser_d;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic [PW-1:0] ptr_next;
  logic          found;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_tc;

  bit_counter #(.W(W)) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .len_i  (len_q),
    .tc_o   (cnt_tc)
  );

  // First asserted request at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign ptr_next = (int'(sel_q) == N - 1) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    len_d    = len_q;
    grant_d  = grant_q;
    ser_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    done     = '0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (found) begin
          sel_d         = pick;
          len_d         = nt[int'(pick)*W +: W];
          cnt_load      = 1'b1;
          grant_d[pick] = 1'b1;
          state_d       = (len_d != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (!req[sel_q]) begin
          // Owner withdrew: drop the channel silently and move the pointer on.
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end else begin
          ser_d  = ser_in[sel_q];
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = grant_q;
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      grant_q <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      grant_q <= grant_d;
      ser_q   <= ser_d;
    end
  end

  assign grant   = grant_q;
  assign ser_out = ser_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters.
REQ-002 SHALL have parameter W, default 8: transfer-length width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N bits: per-requester transfer request, level.
REQ-006 SHALL have port nt, input, N*W bits: bit count per requester; slice i is nt[i*W +: W].
REQ-007 SHALL have port ser_in, input, N bits: per-requester serial data.
REQ-008 SHALL have port ser_out, output, 1 bit: shared serial channel, registered.
REQ-009 SHALL have port grant, output, N bits: one-hot owner of the channel, registered.
REQ-010 SHALL have port done, output, N bits: one-cycle completion pulse to the owner.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, XFER and DONE.
REQ-013 IDLE: SHALL select the first asserted req at or after round-robin pointer ptr, searching upward with wrap N-1 -> 0.
REQ-014 IDLE: on selection, SHALL at the same edge latch sel, latch len = nt[sel] and clear cnt.
REQ-015 IDLE: on selection, SHALL set grant[sel] at the same edge.
REQ-016 IDLE: on selection, SHALL go to XFER if len != 0, else to DONE.
REQ-017 IDLE: with no req asserted, SHALL stay in IDLE with grant = 0.
REQ-018 XFER: each edge SHALL do ser_out <= ser_in[sel] and cnt <= cnt + 1.
REQ-019 XFER: at the edge where cnt == len-1, SHALL go to DONE.
REQ-020 XFER: exactly len bits SHALL be forwarded per transfer.
REQ-021 XFER: changes to nt during the transfer SHALL be ignored.
REQ-022 XFER: req[sel] low at a sampled edge SHALL abort the transfer.
REQ-023 On abort: next state IDLE, grant = 0, no done pulse, ptr = sel+1 mod N.
REQ-024 DONE: SHALL drive done[sel] = 1 for exactly one cycle; grant[sel] stays high.
REQ-025 DONE: at the exit edge SHALL clear grant, set ptr = sel+1 mod N and go to IDLE.
REQ-026 DONE: a new grant SHALL NOT be issued at the exit edge; at least one IDLE cycle follows.
REQ-027 ser_out SHALL be 0 whenever the state is not XFER and the last bit has already been presented.
REQ-028 grant and done SHALL always be one-hot or zero.
REQ-029 Requests arriving mid-transfer SHALL wait; they are arbitrated only in IDLE.
REQ-030 cnt SHALL be W bits wide.
REQ-031 len = 2^W-1 SHALL be supported with no wrap before the terminal count.

Reset
REQ-032 While rst is low: state = IDLE, grant = 0, done = 0, busy = 0, ser_out = 0, ptr = 0, cnt = 0, len = 0, sel = 0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer immediately with no done pulse.
REQ-034 The first arbitration after reset release SHALL start from requester 0.

Structure
REQ-035 State encoding and the default N and W constants SHALL live in package serial_arb_pkg.
REQ-036 The bit counter (load, enable, terminal-count flag) SHALL be sub-module bit_counter.
REQ-037 Round-robin select and the state machine SHALL stay in serial_arbiter.

Verification
REQ-038 N=4, req=0001, nt[0]=5, ser_in[0] pattern 10110 -> grant=0001 for 6 cycles, ser_out=10110, then done=0001 for one cycle.
REQ-039 req=1111 held, all nt=2 -> grants in order 0001, 0010, 0100, 1000, 0001, each followed by a done pulse.
REQ-040 req=0100, nt[2]=0 -> grant=0100 for 1 cycle, done=0100 for that cycle, no ser_out activity.
REQ-041 req[1] with nt=8, req[1] dropped after 3 bits -> grant cleared, no done, next grant goes to the lowest req at or after index 2.
REQ-042 rst pulled low during bit 4 of 8 -> all outputs 0 asynchronously; after release, req=1000 and req=0001 together -> grant=0001.
REQ-043 nt[3]=255 -> exactly 255 ser_out bits, done=1000 once, cnt does not wrap early.
